// File: rtl/chk_stream_arb_if.sv
// chk_stream_arb_if
//   Bundle between the stream arbiter, its character-stream requesters and
//   the shared format checker.
//   req_valid/req_char/req_ready : per-requester char handshake (char i at [8*i+7:8*i])
//   chk_char/chk_reset           : drive the shared checker
//   chk_format_type              : checker verdict
//   res_valid/res_id/res_type/res_abort : tagged one-cycle result pulse
//   busy                         : a message is in progress
//   modport slave  : arbiter side
//   modport master : requester / checker / result-consumer side
interface chk_stream_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_char;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        chk_char;
    logic              chk_reset;
    logic [1:0]        chk_format_type;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [1:0]        res_type;
    logic              res_abort;
    logic              busy;

    modport slave (
        input  req_valid, req_char, chk_format_type,
        output req_ready, chk_char, chk_reset,
        output res_valid, res_id, res_type, res_abort, busy
    );

    modport master (
        output req_valid, req_char, chk_format_type,
        input  req_ready, chk_char, chk_reset,
        input  res_valid, res_id, res_type, res_abort, busy
    );
endinterface

// File: rtl/chk_stream_arb.sv
// chk_stream_arb
//   Shares one format checker among NREQ character-stream producers. A
//   requester presenting '^' while idle wins the checker (round-robin) and
//   keeps it until '#', a stall, or MAXLEN chars. The checker verdict is
//   returned as a tagged one-cycle result.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : chk_stream_arb_if.slave (requester handshake, checker drive, result)
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no owner; drain non-'^' chars, arbitrate among '^' holders
//   ST_BUSY   | forwarding chars of the granted requester
//   ST_RESULT | cycle after '#': checker verdict is sampled
//   ST_ABORT  | stall or over-length: checker held in reset for one cycle
module chk_stream_arb #(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int MAXLEN = 64
) (
    input  logic             clk,
    input  logic             reset,
    chk_stream_arb_if.slave  bus
);

    localparam int          LENW   = $clog2(MAXLEN + 1);
    localparam int unsigned NREQ_U = NREQ;
    localparam logic [7:0]  CH_SOM = 8'h5E;
    localparam logic [7:0]  CH_EOM = 8'h23;
    localparam logic [7:0]  CH_NUL = 8'h00;
    localparam logic [LENW-1:0] LEN_LAST = LENW'(MAXLEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_RESULT = 2'd2,
        ST_ABORT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [LENW-1:0] len_q, len_d;
    logic            res_valid_q, res_valid_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [1:0]      res_type_q, res_type_d;
    logic            res_abort_q, res_abort_d;

    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] ready;
    logic [7:0]      chk_char;
    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic            gnt_valid;
    logic [7:0]      gnt_char;
    logic [LENW-1:0] len_inc;

    // (base + step) mod NREQ; both operands are below NREQ so one subtract suffices.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base,
                                              input int unsigned step);
        int unsigned s;
        s = {{(32-IDW){1'b0}}, base} + step;
        if (s >= NREQ_U) s = s - NREQ_U;
        return s[IDW-1:0];
    endfunction

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign cand[gi] = bus.req_valid[gi] && (bus.req_char[8*gi +: 8] == CH_SOM);
    end

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            if (!win_found && cand[rr_idx(rr_ptr_q, k)]) begin
                win_found = 1'b1;
                win_id    = rr_idx(rr_ptr_q, k);
            end
        end
    end

    assign gnt_valid = bus.req_valid[grant_q];
    assign gnt_char  = bus.req_char[{grant_q, 3'b000} +: 8];
    assign len_inc   = (len_q == '1) ? len_q : len_q + LENW'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        len_d       = len_q;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_type_d  = res_type_q;
        res_abort_d = res_abort_q;
        ready       = '0;
        chk_char    = CH_NUL;

        case (state_q)
            ST_IDLE: begin
                // Stray chars are consumed so a requester cannot wedge the
                // arbiter; losing '^' holders simply wait.
                ready = bus.req_valid & ~cand;
                if (win_found) begin
                    ready[win_id] = 1'b1;
                    chk_char      = CH_SOM;
                    grant_d       = win_id;
                    rr_ptr_d      = rr_idx(win_id, 1);
                    len_d         = LENW'(1);
                    state_d       = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (gnt_valid) begin
                    ready[grant_q] = 1'b1;
                    chk_char       = gnt_char;
                    len_d          = len_inc;
                    if (gnt_char == CH_EOM) begin
                        state_d = ST_RESULT;
                    end else if (len_q == LEN_LAST) begin
                        state_d = ST_ABORT;
                    end
                end else begin
                    state_d = ST_ABORT;
                end
            end
            ST_RESULT: begin
                res_valid_d = 1'b1;
                res_id_d    = grant_q;
                res_type_d  = bus.chk_format_type;
                res_abort_d = 1'b0;
                state_d     = ST_IDLE;
            end
            ST_ABORT: begin
                res_valid_d = 1'b1;
                res_id_d    = grant_q;
                res_type_d  = 2'd0;
                res_abort_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Nothing is accepted or forwarded while reset is asserted.
        if (reset) begin
            ready    = '0;
            chk_char = CH_NUL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            len_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_type_q  <= 2'd0;
            res_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            len_q       <= len_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_type_q  <= res_type_d;
            res_abort_q <= res_abort_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.chk_char  = chk_char;
    assign bus.chk_reset = reset | (state_q == ST_ABORT);
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_type  = res_type_q;
    assign bus.res_abort = res_abort_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule
